// File: rtl/fifo_wr_arb.sv
// Round-robin, burst-locked arbiter sharing one packed-word FIFO write port
// between NUM_REQ packer channels; grants only when a full burst fits.
module fifo_wr_arb #(
  parameter int unsigned NUM_REQ         = 4,
  parameter int unsigned AXI4_DATA_WIDTH = 128,
  parameter int unsigned FAW             = 8,
  parameter int unsigned BURST_LEN       = 16,
  localparam int unsigned GW             = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                               ACLK,
  input  logic                               ARESET,
  input  logic [NUM_REQ-1:0]                 req_vld,
  input  logic [NUM_REQ*AXI4_DATA_WIDTH-1:0] req_dat,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_rdy,
  input  logic                               fwr_rdy,
  output logic                               fwr_vld,
  output logic [AXI4_DATA_WIDTH-1:0]         fwr_dat,
  input  logic                               fwr_full,
  input  logic [FAW:0]                       fwr_cnt,
  output logic [GW-1:0]                      grant_id,
  output logic                               busy
);

  typedef enum logic {IDLE, XFER} state_t;

  localparam logic [FAW:0]   DEPTH     = {1'b1, {FAW{1'b0}}};
  localparam logic [FAW+1:0] NEED      = (FAW+2)'(BURST_LEN + 1);
  localparam logic [FAW:0]   LAST_BEAT = (FAW+1)'(BURST_LEN - 1);
  localparam logic [FAW:0]   BEAT_ONE  = {{FAW{1'b0}}, 1'b1};

  state_t                     state_q;
  logic [GW-1:0]              grant_q;
  logic [FAW:0]               beat_q;
  logic [FAW:0]               beat_d;
  logic                       fwr_vld_q;
  logic [AXI4_DATA_WIDTH-1:0] fwr_dat_q;

  logic [FAW:0]               space;
  logic                       admit;
  logic                       port_ok;
  logic                       in_xfer;
  logic                       g_vld;
  logic                       g_last;
  logic [AXI4_DATA_WIDTH-1:0] g_dat;
  logic                       accept;
  logic                       done;
  logic                       pick_vld;
  logic [GW-1:0]              pick;
  logic [GW-1:0]              cand;

  // One spare word beyond the burst absorbs the registered output stage
  assign space   = DEPTH - fwr_cnt;
  assign admit   = ({1'b0, space} >= NEED) && !fwr_full && fwr_rdy;
  assign port_ok = fwr_rdy && !fwr_full;
  assign in_xfer = (state_q == XFER);

  assign g_vld  = req_vld[grant_q];
  assign g_last = req_last[grant_q];
  assign g_dat  = req_dat[32'(grant_q)*AXI4_DATA_WIDTH +: AXI4_DATA_WIDTH];

  assign accept = in_xfer && g_vld && port_ok;
  assign done   = accept && (g_last || (beat_q == LAST_BEAT));
  assign beat_d = beat_q + BEAT_ONE;

  // First requester strictly after the last grant, wrapping around
  always_comb begin
    pick_vld = 1'b0;
    pick     = grant_q;
    cand     = grant_q;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = GW'((32'(grant_q) + k) % NUM_REQ);
      if (!pick_vld && req_vld[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  always_comb begin
    req_rdy = '0;
    if (in_xfer) req_rdy[grant_q] = port_ok;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      grant_q   <= GW'(NUM_REQ - 1);
      beat_q    <= '0;
      fwr_vld_q <= 1'b0;
      fwr_dat_q <= '0;
    end else begin
      fwr_vld_q <= accept;
      fwr_dat_q <= accept ? g_dat : '0;
      case (state_q)
        IDLE: begin
          if (admit && pick_vld) begin
            grant_q <= pick;
            beat_q  <= '0;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            beat_q <= beat_d;
            if (done) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fwr_vld  = fwr_vld_q;
  assign fwr_dat  = fwr_dat_q;
  assign grant_id = grant_q;
  assign busy     = in_xfer;

endmodule
